// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin share of one calculator between two requesters, results routed back in issue order
module calc_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  r0_inpA,
  input  logic [7:0]  r1_inpA,
  input  logic [7:0]  r0_inpB,
  input  logic [7:0]  r1_inpB,
  input  logic [1:0]  r0_opType,
  input  logic [1:0]  r1_opType,
  input  logic        r0_iValid,
  input  logic        r1_iValid,
  output logic        r0_iStall,
  output logic        r1_iStall,
  output logic [15:0] r0_outC,
  output logic [15:0] r1_outC,
  output logic        r0_oValid,
  output logic        r1_oValid,
  input  logic        r0_oStall,
  input  logic        r1_oStall,
  output logic [7:0]  c_inpA,
  output logic [7:0]  c_inpB,
  output logic [1:0]  c_opType,
  output logic        c_iValid,
  input  logic        c_iStall,
  input  logic [15:0] c_outC,
  input  logic        c_oValid,
  output logic        c_oStall
);
  localparam int AW = $clog2(TAG_DEPTH);
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic          rr_q, rr_d;
  logic          tags_q [TAG_DEPTH];
  logic          can_issue, g0, g1, issue, busy, h, pop;
  always_comb begin
    can_issue = !c_iStall && (cnt_q < (AW+1)'(TAG_DEPTH));
    g0        = can_issue && r0_iValid && (!r1_iValid || !rr_q);
    g1        = can_issue && r1_iValid && (!r0_iValid || rr_q);
    issue     = g0 || g1;
    c_iValid  = issue;
    c_inpA    = g1 ? r1_inpA : r0_inpA;
    c_inpB    = g1 ? r1_inpB : r0_inpB;
    c_opType  = g1 ? r1_opType : r0_opType;
    r0_iStall = r0_iValid && !g0;
    r1_iStall = r1_iValid && !g1;
    busy      = cnt_q != '0;
    h         = tags_q[rp_q];
    r0_oValid = busy && !h && c_oValid;
    r1_oValid = busy && h && c_oValid;
    r0_outC   = (busy && !h) ? c_outC : '0;
    r1_outC   = (busy && h) ? c_outC : '0;
    c_oStall  = !busy || (h ? r1_oStall : r0_oStall);
    pop       = c_oValid && !c_oStall;
    cnt_d     = cnt_q + (AW+1)'(issue) - (AW+1)'(pop);
    wp_d      = wp_q + AW'(issue);
    rp_d      = rp_q + AW'(pop);
    rr_d      = issue ? !g1 : rr_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      rr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      rr_q  <= rr_d;
    end
  end
  always_ff @(posedge clk)
    if (issue) tags_q[wp_q] <= g1;
endmodule
